// File: rtl/score_recorder_if.sv
// rtl/score_recorder_if.sv - key/control inputs and score RAM write port of score_recorder
interface score_recorder_if #(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_LENGTH  = 4
);
  logic                    record;
  logic                    stop;
  logic                    key_c;
  logic                    key_d;
  logic                    key_e;
  logic                    read_or_write;
  logic [ADDRESS_BITS-1:0] address;
  logic [DATA_LENGTH-1:0]  key_input;
  logic [DATA_LENGTH-1:0]  time_input;
  logic                    recording;
  logic                    end_of_score;

  modport master (
    output record, stop, key_c, key_d, key_e,
    input  read_or_write, address, key_input, time_input, recording, end_of_score
  );

  modport slave (
    input  record, stop, key_c, key_d, key_e,
    output read_or_write, address, key_input, time_input, recording, end_of_score
  );
endinterface

// File: rtl/score_recorder.sv
// rtl/score_recorder.sv - records C/D/E key presses as {code, duration} entries plus end marker
// Optional rest entries between notes: SCORE_RECORDER_RESTS_EN.
module score_recorder #(
  parameter int ADDRESS_BITS = 5,
  parameter int DATA_LENGTH  = 4,
  parameter int TICK_CYCLES  = 5000000,
  parameter logic [DATA_LENGTH-1:0] END_CODE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  score_recorder_if.slave  bus
);
`ifdef SCORE_RECORDER_RESTS_EN
  localparam bit RESTS_EN = 1'b1;
`else
  localparam bit RESTS_EN = 1'b0;
`endif

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0]       TICK_LAST       = TICK_W'(TICK_CYCLES - 1);
  localparam logic [DATA_LENGTH-1:0]  DUR_SAT_PREV    = DATA_LENGTH'((1 << DATA_LENGTH) - 2);
  localparam logic [ADDRESS_BITS-1:0] ADDR_LAST_ENTRY = ADDRESS_BITS'((1 << ADDRESS_BITS) - 2);
  localparam logic [DATA_LENGTH-1:0]  CODE_REST       = DATA_LENGTH'(0);
  localparam logic [DATA_LENGTH-1:0]  CODE_C          = DATA_LENGTH'(1);
  localparam logic [DATA_LENGTH-1:0]  CODE_D          = DATA_LENGTH'(2);
  localparam logic [DATA_LENGTH-1:0]  CODE_E          = DATA_LENGTH'(3);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_REC  = 3'd2;
  localparam logic [2:0] S_END  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]              state, state_d;
  logic [2:0]              keys_q;
  logic [DATA_LENGTH-1:0]  code, cur_code, open_code;
  logic [TICK_W-1:0]       tick;
  logic [DATA_LENGTH-1:0]  dur, done_ticks, close_time;
  logic                    tick_wrap;
  logic [ADDRESS_BITS-1:0] addr_base;
  logic                    wr_en, wr_marker, open, rec_start, finish;
  logic [DATA_LENGTH-1:0]  wr_key, wr_time;

  logic                    row_q;
  logic [ADDRESS_BITS-1:0] address_q;
  logic [DATA_LENGTH-1:0]  key_q, time_q;
  logic                    recording_q, eos_q;

  assign bus.read_or_write = row_q;
  assign bus.address       = address_q;
  assign bus.key_input     = key_q;
  assign bus.time_input    = time_q;
  assign bus.recording     = recording_q;
  assign bus.end_of_score  = eos_q;

  always_comb begin
    code = CODE_REST;
    if (keys_q[2])      code = CODE_C;
    else if (keys_q[1]) code = CODE_D;
    else if (keys_q[0]) code = CODE_E;
  end

  // The closing edge itself completes a cycle, so a wrapping tick counts toward the entry.
  assign tick_wrap  = (tick == TICK_LAST);
  assign done_ticks = dur + DATA_LENGTH'(tick_wrap);
  assign close_time = (done_ticks == '0) ? DATA_LENGTH'(1) : done_ticks;
  assign addr_base  = row_q ? address_q : address_q + ADDRESS_BITS'(1);

  always_comb begin
    state_d   = state;
    wr_en     = 1'b0;
    wr_marker = 1'b0;
    wr_key    = cur_code;
    wr_time   = close_time;
    open      = 1'b0;
    open_code = code;
    rec_start = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.record && !bus.stop) begin
          state_d   = S_ARM;
          rec_start = 1'b1;
        end
      end
      S_ARM: begin
        if (bus.stop) begin
          wr_marker = 1'b1;
          state_d   = S_DONE;
        end else if (code != CODE_REST) begin
          open    = 1'b1;
          state_d = S_REC;
        end
      end
      S_REC: begin
        if (bus.stop) begin
          if (cur_code != CODE_REST) begin
            wr_en   = 1'b1;
            state_d = S_END;
          end else begin
            wr_marker = 1'b1;
            state_d   = S_DONE;
          end
        end else if (code != cur_code) begin
          wr_en = 1'b1;
          if (code == CODE_REST && !RESTS_EN) state_d = S_ARM;
          else                                open    = 1'b1;
        end else if (tick_wrap && dur == DUR_SAT_PREV) begin
          wr_en = 1'b1;
          open  = 1'b1;
        end
      end
      S_END: begin
        wr_marker = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The last address is reserved for the marker, so an entry landing just below it ends the score.
    if (wr_en && addr_base == ADDR_LAST_ENTRY) begin
      state_d = S_END;
      open    = 1'b0;
    end
    if (wr_marker) begin
      wr_key  = END_CODE;
      wr_time = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      keys_q      <= '0;
      cur_code    <= '0;
      tick        <= '0;
      dur         <= '0;
      row_q       <= 1'b1;
      address_q   <= '0;
      key_q       <= '0;
      time_q      <= '0;
      recording_q <= 1'b0;
      eos_q       <= 1'b0;
    end else begin
      keys_q    <= {bus.key_c, bus.key_d, bus.key_e};
      state     <= state_d;
      row_q     <= !(wr_en || wr_marker);
      address_q <= rec_start ? '0 : addr_base;
      if (wr_en || wr_marker) begin
        key_q  <= wr_key;
        time_q <= wr_time;
      end
      if (open) begin
        cur_code <= open_code;
        tick     <= '0;
        dur      <= '0;
      end else if (state == S_REC) begin
        if (tick_wrap) begin
          tick <= '0;
          dur  <= dur + DATA_LENGTH'(1);
        end else begin
          tick <= tick + TICK_W'(1);
        end
      end
      if (rec_start) begin
        recording_q <= 1'b1;
        eos_q       <= 1'b0;
      end
      if (finish) begin
        recording_q <= 1'b0;
        eos_q       <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_score_recorder.sv
// tb/tb_score_recorder.sv - directed scoreboard bench for score_recorder with TICK_CYCLES = 4
module tb_score_recorder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [12:0] exp_q[$];

  score_recorder_if #(.ADDRESS_BITS(5), .DATA_LENGTH(4)) bus ();

  score_recorder #(
    .ADDRESS_BITS(5),
    .DATA_LENGTH(4),
    .TICK_CYCLES(4),
    .END_CODE(4'hF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every RAM write strobe must match the oldest expected {address, key, time}.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.read_or_write !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL write_unexpected observed=%0h expected=none",
               {bus.address, bus.key_input, bus.time_input});
      end else begin
        chk("write", {19'd0, bus.address, bus.key_input, bus.time_input}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_wr(input int a, input int k, input int t);
    exp_q.push_back({5'(a), 4'(k), 4'(t)});
  endtask

  task automatic set_keys(input logic c, input logic d, input logic e);
    bus.key_c = c;
    bus.key_d = d;
    bus.key_e = e;
  endtask

  task automatic pulse_record;
    bus.record = 1'b1;
    step(1);
    bus.record = 1'b0;
  endtask

  task automatic pulse_stop;
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.end_of_score !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    chk({tag, "_eos"}, 32'(bus.end_of_score), 32'd1);
    chk({tag, "_recording"}, 32'(bus.recording), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.record = 1'b0;
    bus.stop = 1'b0;
    set_keys(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_row", 32'(bus.read_or_write), 32'd1);
    chk("reset_addr", 32'(bus.address), 32'd0);
    chk("reset_key", 32'(bus.key_input), 32'd0);
    chk("reset_time", 32'(bus.time_input), 32'd0);
    chk("reset_recording", 32'(bus.recording), 32'd0);
    chk("reset_eos", 32'(bus.end_of_score), 32'd0);
    rst_n = 1'b1;
    step(2);

    // Single note: C held 10 cycles -> {1,2}, marker at 1
    pulse_record;
    chk("t1_recording", 32'(bus.recording), 32'd1);
    expect_wr(0, 1, 2);
    set_keys(1'b1, 1'b0, 1'b0);
    step(10);
    set_keys(1'b0, 1'b0, 1'b0);
    step(4);
    expect_wr(1, 15, 0);
    pulse_stop;
    wait_done("t1");

    // Record and Stop together in IDLE: Stop wins
    bus.record = 1'b1;
    bus.stop = 1'b1;
    step(1);
    bus.record = 1'b0;
    bus.stop = 1'b0;
    step(2);
    chk("rs_recording", 32'(bus.recording), 32'd0);
    chk("rs_eos_held", 32'(bus.end_of_score), 32'd1);

    // Stop straight from ARM: marker written one cycle later at address 0
    pulse_record;
    chk("arm_eos_cleared", 32'(bus.end_of_score), 32'd0);
    expect_wr(0, 15, 0);
    bus.stop = 1'b1;
    step(1);
    bus.stop = 1'b0;
    chk("arm_stop_row", 32'(bus.read_or_write), 32'd0);
    chk("arm_stop_addr", 32'(bus.address), 32'd0);
    wait_done("arm_stop");

    // Saturation: D held 70 cycles -> {2,15}, {2,2}
    pulse_record;
    expect_wr(0, 2, 15);
    expect_wr(1, 2, 2);
    set_keys(1'b0, 1'b1, 1'b0);
    step(70);
    set_keys(1'b0, 1'b0, 1'b0);
    step(4);
    expect_wr(2, 15, 0);
    pulse_stop;
    wait_done("t2");

    // Priority: C+E -> code 1, drop C -> code 3, then short D press -> time 1
    pulse_record;
    expect_wr(0, 1, 1);
    expect_wr(1, 3, 1);
    expect_wr(2, 2, 1);
    set_keys(1'b1, 1'b0, 1'b1);
    step(6);
    set_keys(1'b0, 1'b0, 1'b1);
    step(6);
    set_keys(1'b0, 1'b1, 1'b0);
    step(2);
    set_keys(1'b0, 1'b0, 1'b0);
    step(4);
    expect_wr(3, 15, 0);
    pulse_stop;
    wait_done("t3");

    // Full: 31 alternating notes fill 0..30, marker at 31 without Stop
    pulse_record;
    for (int i = 0; i < 31; i++) expect_wr(i, (i % 2 == 0) ? 1 : 2, 1);
    expect_wr(31, 15, 0);
    for (int i = 0; i < 32; i++) begin
      set_keys((i % 2) == 0, (i % 2) == 1, 1'b0);
      step(4);
    end
    set_keys(1'b0, 1'b0, 1'b0);
    wait_done("t4");
    set_keys(1'b1, 1'b0, 1'b0);
    step(8);
    set_keys(1'b0, 1'b0, 1'b0);
    step(4);
    chk("t4_no_write_row", 32'(bus.read_or_write), 32'd1);
    chk("t4_still_idle", 32'(bus.recording), 32'd0);

    // Reset mid-recording: immediate abort, no write, restart at 0
    pulse_record;
    set_keys(1'b1, 1'b0, 1'b0);
    step(6);
    rst_n = 1'b0;
    #1;
    chk("t5_row", 32'(bus.read_or_write), 32'd1);
    chk("t5_recording", 32'(bus.recording), 32'd0);
    chk("t5_addr", 32'(bus.address), 32'd0);
    step(2);
    set_keys(1'b0, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(6);
    pulse_record;
    expect_wr(0, 1, 1);
    set_keys(1'b1, 1'b0, 1'b0);
    step(4);
    set_keys(1'b0, 1'b0, 1'b0);
    step(4);
    expect_wr(1, 15, 0);
    pulse_stop;
    wait_done("t5");

    // Gap handling: C 8, gap 8, D 8
    pulse_record;
    expect_wr(0, 1, 2);
`ifdef SCORE_RECORDER_RESTS_EN
    expect_wr(1, 0, 2);
    expect_wr(2, 2, 2);
    expect_wr(3, 15, 0);
`else
    expect_wr(1, 2, 2);
    expect_wr(2, 15, 0);
`endif
    set_keys(1'b1, 1'b0, 1'b0);
    step(8);
    set_keys(1'b0, 1'b0, 1'b0);
    step(8);
    set_keys(1'b0, 1'b1, 1'b0);
    step(8);
    set_keys(1'b0, 1'b0, 1'b0);
    step(4);
    pulse_stop;
    wait_done("t6");

    step(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
